// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
//
// Shared definitions for the multiplexed seven-segment display driver:
//   - active-high segment patterns for the sixteen hex digits
//     (segments a..g map to bit0..bit6)
//   - SEG_OFF, the active-high "all segments dark" pattern
//   - disp_mode_e, the reason a digit is shown or suppressed this cycle
//   - cnt_width(), the register width needed to count 0..range-1 (min 1)
//   - hex_to_seg(), nibble to active-high segment pattern
// -----------------------------------------------------------------------------
package hex_display_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;  // lower-case b
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;  // lower-case d
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Dark digit in active-high terms; the top applies output polarity.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Why the currently scanned digit is lit or dark.
  typedef enum logic [1:0] {
    DISP_SHOW      = 2'd0,
    DISP_LZ_BLANK  = 2'd1,
    DISP_BLINK_OFF = 2'd2
  } disp_mode_e;

  // Width of a counter that runs 0..range-1. A range of 1 still gets one bit
  // so that every counter is a real (if constant) register.
  function automatic int unsigned cnt_width(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage : hex_display_pkg

// File: rtl/hex_seg_encode.sv
// -----------------------------------------------------------------------------
// hex_seg_encode
//
// Purely combinational hex nibble to seven-segment decoder. The output is
// always active-high (lit = 1); blanking and pin polarity are handled by the
// caller so that a single decoder can serve every digit of a scanned bank.
//
// Ports
//   nibble_i  in   4  hex digit to decode
//   seg_o     out  7  segments a..g = bit0..bit6, active-high
// -----------------------------------------------------------------------------
module hex_seg_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
  end

endmodule : hex_seg_encode

// File: rtl/hex_display_scan.sv
// -----------------------------------------------------------------------------
// hex_display_scan
//
// Time-multiplexed driver for N_DIGITS seven-segment digits on a shared
// segment bus. A multi-nibble value is captured atomically into a shadow
// register; one digit at a time is decoded from the shadow and driven out
// together with a one-hot digit enable. Supports leading-zero blanking, a
// whole-display blink and a once-per-frame tick.
//
// Parameters
//   N_DIGITS        number of digits / nibbles (>= 1)
//   SCAN_DIV        clock cycles each digit stays enabled (>= 1)
//   BLINK_FRAMES    full scan frames per blink half-period (>= 1)
//   SEG_ACTIVE_LOW  1 inverts seg at the pins (lit = 0)
//
// Ports
//   clk         in   1           rising-edge clock
//   resetn      in   1           asynchronous active-low reset
//   load        in   1           capture value into the shadow this edge
//   value       in   4*N_DIGITS  nibble i = value[4i+3:4i], digit 0 = LSN
//   lz_blank    in   1           enable leading-zero blanking
//   blink_en    in   1           enable blinking of all digits
//   seg         out  7           segments a..g = bit0..bit6, registered
//   dig_en      out  N_DIGITS    one-hot digit enable (active-high), registered
//   frame_tick  out  1           one-cycle pulse aligned with digit 0 re-enabling
// -----------------------------------------------------------------------------
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_FRAMES   = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  lz_blank,
  input  logic                  blink_en,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_tick
);

  localparam int unsigned DIV_W = cnt_width(SCAN_DIV);
  localparam int unsigned IDX_W = cnt_width(N_DIGITS);
  localparam int unsigned FRM_W = cnt_width(BLINK_FRAMES);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  // Dark pattern as it appears on the pins.
  localparam logic [6:0] SEG_OFF_PIN = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0]      div_q,    div_d;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [FRM_W-1:0]      frm_q,    frm_d;
  logic                  phase_q,  phase_d;   // 1 = visible half of blink
  logic                  wrap_q;              // idx wrapped to 0 on the last edge
  logic [6:0]            seg_q,    seg_d;
  logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                  frame_tick_q;

  // ---------------------------------------------------------------------------
  // Scan timing: divider -> digit index -> frame count -> blink phase
  // ---------------------------------------------------------------------------
  logic div_wrap;
  logic frame_wrap;

  assign div_wrap   = (div_q == DIV_LAST);
  assign frame_wrap = div_wrap && (idx_q == IDX_LAST);

  // NOTE: every signal driven from always_comb gets a default on entry so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    shadow_d = shadow_q;
    div_d    = div_q;
    idx_d    = idx_q;
    frm_d    = frm_q;
    phase_d  = phase_q;

    if (load) begin
      shadow_d = value;
    end

    div_d = div_wrap ? '0 : div_q + 1'b1;

    if (div_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // The blink phase free-runs so enabling blink_en lands mid-period rather
    // than restarting the blink.
    if (frame_wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d   = frm_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit select and leading-zero detection on the shadow register
  // ---------------------------------------------------------------------------
  logic [N_DIGITS-1:0] zero_from;  // bit i: nibbles i..N_DIGITS-1 are all zero
  logic [3:0]          cur_nibble;
  logic                cur_lz;     // current digit qualifies for lz blanking
  logic                run_zero;

  always_comb begin
    zero_from = '0;
    run_zero  = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero && (shadow_q[4*i +: 4] == 4'h0);
      zero_from[i] = run_zero;
    end
  end

  always_comb begin
    cur_nibble = 4'h0;
    cur_lz     = 1'b0;
    dig_en_d   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nibble  = shadow_q[4*i +: 4];
        // Digit 0 always shows, so an all-zero value still reads "0".
        cur_lz      = (i != 0) && zero_from[i];
        dig_en_d[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode, suppression and output polarity
  // ---------------------------------------------------------------------------
  logic [6:0] dec_seg;
  logic [6:0] seg_lit;
  disp_mode_e disp_mode;

  hex_seg_encode u_encode (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    disp_mode = DISP_SHOW;
    if (lz_blank && cur_lz) begin
      disp_mode = DISP_LZ_BLANK;
    end else if (blink_en && !phase_q) begin
      disp_mode = DISP_BLINK_OFF;
    end

    seg_lit = (disp_mode == DISP_SHOW) ? dec_seg : SEG_OFF;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the shadow is a plain register bank, not a memory, so it is reset
  // like any other flop; a freshly reset display reads "0" rather than noise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q     <= '0;
      div_q        <= '0;
      idx_q        <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b1;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_OFF_PIN;
      dig_en_q     <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      wrap_q       <= frame_wrap;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
      // Delayed one extra edge so the pulse coincides with dig_en showing
      // digit 0 again, not with the internal index wrap.
      frame_tick_q <= wrap_q;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule : hex_display_scan

// File: tb/tb_hex_display_scan.sv
// -----------------------------------------------------------------------------
// tb_hex_display_scan
//
// Three instances share clock and reset:
//   dut_a  N_DIGITS=4 SCAN_DIV=4 BLINK_FRAMES=2 active-high segments
//   dut_b  same as dut_a with SEG_ACTIVE_LOW=1, same inputs
//   dut_c  N_DIGITS=1 SCAN_DIV=1 BLINK_FRAMES=2, own load/value
// Expected outputs come from a reference model computed from the cycle count
// since reset release: digit = (cycle / dwell) mod digits, blink half-period
// from the frame count, and a one-edge pipeline from shadow to pins.
// -----------------------------------------------------------------------------
module tb_hex_display_scan;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [32:0] RST_EXP =
    {7'h00, 4'h0, 1'b0, 7'h7F, 4'h0, 1'b0, 7'h00, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        resetn;
  logic        load, load_c;
  logic [15:0] value;
  logic [3:0]  value_c;
  logic        lz_blank, blink_en;

  logic [6:0] seg_a, seg_b, seg_c;
  logic [3:0] dig_a, dig_b;
  logic [0:0] dig_c;
  logic       ft_a, ft_b, ft_c;

  always #5 clk = ~clk;

  hex_display_scan #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg_a), .dig_en(dig_a), .frame_tick(ft_a));

  hex_display_scan #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg_b), .dig_en(dig_b), .frame_tick(ft_b));

  hex_display_scan #(.N_DIGITS(1), .SCAN_DIV(1), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .resetn(resetn), .load(load_c), .value(value_c), .lz_blank(lz_blank),
    .blink_en(blink_en), .seg(seg_c), .dig_en(dig_c), .frame_tick(ft_c));

  logic [32:0] obs_all;
  assign obs_all = {seg_a, dig_a, ft_a, seg_b, dig_b, ft_b, seg_c, dig_c, ft_c};

  // Model state
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          k;          // edges since reset release
  logic [15:0] m_sh;       // shadow of dut_a/dut_b
  logic [3:0]  m_sh_c;     // shadow of dut_c
  logic [32:0] exp_all;

  // Segment pattern a display with n digits of s-cycle dwell shows on edge kk.
  function automatic logic [6:0] model_seg(int n, int s, int b, bit al, int kk,
                                           logic [15:0] sh, bit lz, bit bl);
    int         p;
    int         idx;
    logic [15:0] upper;
    bit         off;
    logic [6:0] r;
    p     = kk - 1;
    idx   = (p / s) % n;
    upper = sh >> (4 * idx);
    off   = (lz && idx > 0 && upper == 16'h0) || (bl && ((p / (n * s * b)) % 2 == 1));
    r     = off ? 7'h00 : SEG_TAB[upper[3:0]];
    return al ? ~r : r;
  endfunction

  // Advance one clock edge and compute the outputs expected just after it.
  task automatic tick();
    bit          lz  = lz_blank;
    bit          bl  = blink_en;
    bit          ld  = load;
    logic [15:0] v   = value;
    bit          ldc = load_c;
    logic [3:0]  vc  = value_c;
    logic [3:0]  e_dig;
    bit          e_ft;
    @(posedge clk);
    k++;
    e_dig   = 4'(1 << (((k - 1) / 4) % 4));
    e_ft    = (k >= 2) && ((k - 1) % 16 == 0);
    exp_all = {model_seg(4, 4, 2, 1'b0, k, m_sh, lz, bl), e_dig, e_ft,
               model_seg(4, 4, 2, 1'b1, k, m_sh, lz, bl), e_dig, e_ft,
               model_seg(1, 1, 2, 1'b0, k, {12'h0, m_sh_c}, lz, bl), 1'b1, (k >= 2)};
    if (ld)  m_sh   = v;
    if (ldc) m_sh_c = vc;
    #1;
  endtask

  task automatic release_reset();
    load    = 1'b0;
    load_c  = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    k       = 0;
    m_sh    = 16'h0;
    m_sh_c  = 4'h0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs_all !== RST_EXP) begin
      tests_failed++;
      $display("FAIL reset_state got %h want %h", obs_all, RST_EXP);
    end
    release_reset();
    tick();
    tests_run++;
    if (obs_all !== exp_all) begin
      tests_failed++;
      $display("FAIL first_edge got %h want %h", obs_all, exp_all);
    end
  endtask

  task automatic test_scan();
    load  = 1'b1;
    value = 16'h12AF;
    tick();
    load  = 1'b0;
    repeat (48) begin
      tick();
      tests_run++;
      if (obs_all !== exp_all) begin
        tests_failed++;
        $display("FAIL scan k=%0d got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] pats [3] = '{16'h0000, 16'h0300, 16'h0008};
    lz_blank = 1'b1;
    for (int j = 0; j < 3; j++) begin
      load  = 1'b1;
      value = pats[j];
      tick();
      load  = 1'b0;
      repeat (20) begin
        tick();
        tests_run++;
        if (obs_all !== exp_all) begin
          tests_failed++;
          $display("FAIL lz_blank v=%h k=%0d got %h want %h", pats[j], k, obs_all, exp_all);
        end
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_blink();
    blink_en = 1'b1;
    load     = 1'b1;
    value    = 16'h5A3C;
    tick();
    load     = 1'b0;
    repeat (80) begin
      tick();
      tests_run++;
      if (obs_all !== exp_all) begin
        tests_failed++;
        $display("FAIL blink k=%0d got %h want %h", k, obs_all, exp_all);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    load  = 1'b1;
    value = 16'h9876;
    tick();
    load  = 1'b0;
    while (exp_all[25:22] != 4'b0100 && budget < 64) begin
      tick();
      budget++;
    end
    tests_run++;
    if (budget >= 64) begin
      tests_failed++;
      $display("FAIL reset_mid_reach_digit2 budget=%0d", budget);
    end
    tick();  // now mid-way through digit 2's dwell
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (obs_all !== RST_EXP) begin
      tests_failed++;
      $display("FAIL reset_mid_async got %h want %h", obs_all, RST_EXP);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (obs_all !== RST_EXP) begin
      tests_failed++;
      $display("FAIL reset_mid_held got %h want %h", obs_all, RST_EXP);
    end
    release_reset();
    tick();
    tests_run++;
    if (obs_all !== exp_all || dig_a !== 4'b0001 || seg_a !== 7'h3F) begin
      tests_failed++;
      $display("FAIL reset_mid_restart got %h want %h", obs_all, exp_all);
    end
    repeat (20) begin
      tick();
      tests_run++;
      if (obs_all !== exp_all) begin
        tests_failed++;
        $display("FAIL reset_mid_after k=%0d got %h want %h", k, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_load_on_advance();
    logic [3:0] prev_vc;
    blink_en = 1'b0;
    load_c   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      value_c = 4'($urandom);
      tick();
      tests_run++;
      if (obs_all !== exp_all || (i > 0 && (seg_c !== SEG_TAB[prev_vc] || ft_c !== 1'b1))) begin
        tests_failed++;
        $display("FAIL load_on_advance i=%0d seg_c=%h ft_c=%b got %h want %h",
                 i, seg_c, ft_c, obs_all, exp_all);
      end
      prev_vc = value_c;
    end
    load_c = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] v;
    repeat (500) begin
      v = 16'h0;
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(1, 0) == 1) v[4*j +: 4] = 4'($urandom);
      end
      value   = v;
      load    = ($urandom_range(3, 0) == 0);
      value_c = 4'($urandom);
      load_c  = ($urandom_range(1, 0) == 1);
      if ($urandom_range(15, 0) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(31, 0) == 0) blink_en = ~blink_en;
      tick();
      tests_run++;
      if (obs_all !== exp_all) begin
        tests_failed++;
        $display("FAIL random k=%0d got %h want %h", k, obs_all, exp_all);
      end
    end
    load   = 1'b0;
    load_c = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn   = 1'b1;
    load     = 1'b0;
    load_c   = 1'b0;
    value    = 16'h0;
    value_c  = 4'h0;
    lz_blank = 1'b0;
    blink_en = 1'b0;
    k        = 0;
    m_sh     = 16'h0;
    m_sh_c   = 4'h0;
    exp_all  = '0;
    #2;
    resetn   = 1'b0;

    test_reset();
    test_scan();
    test_lz_blank();
    test_blink();
    test_reset_mid();
    test_load_on_advance();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_hex_display_scan

// File: doc/hex_display_scan.md
# hex_display_scan

Time-multiplexed driver for a bank of N seven-segment digits, the parametrised successor to the single-digit hex decoder. A multi-nibble value is latched atomically, decoded per digit, and scanned out over a shared segment bus with a one-hot digit enable. It adds leading-zero blanking, a blink mode and a frame tick. It sits between datapath registers and the board display pins.

## Interface
- N_DIGITS, 4: number of digits/nibbles, ≥1
- SCAN_DIV, 50000: clock cycles each digit stays enabled, ≥1
- BLINK_FRAMES, 250: full scan frames per blink half-period, ≥1
- SEG_ACTIVE_LOW, 0: 1 inverts `seg` at the output (lit = 0); `dig_en` is always active-high
- clk  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- load  in  1  latch `value` into the shadow register this edge
- value  in  4*N_DIGITS  nibble i = value[4i+3:4i], digit 0 = least significant
- lz_blank  in  1  enable leading-zero blanking
- blink_en  in  1  enable blinking of all digits
- seg  out  7  segments a..g = bit0..bit6, registered
- dig_en  out  N_DIGITS  one-hot digit enable, registered
- frame_tick  out  1  one-cycle pulse when the scan index wraps N_DIGITS-1 -> 0

## Operation
- Shadow register: loaded from `value` on any edge with load=1. All decode reads only the shadow, so no digit ever shows a half-updated value.
- Divider `div` counts 0..SCAN_DIV-1. On wrap, digit index `idx` advances 0..N_DIGITS-1 and wraps to 0. Counter widths are $clog2 of their range, min 1.
- Decode, with active-high lit segments: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Leading-zero blank: with lz_blank=1, digit i>0 is blanked when nibbles i..N_DIGITS-1 are all zero. Digit 0 is never blanked by this rule.
- Blink: `phase` toggles after every BLINK_FRAMES frame wraps and runs regardless of blink_en. When blink_en=1 and phase=0, seg is forced off while dig_en keeps scanning. With blink_en=0 the display is always visible.
- "Off" means seg=7'h00 when SEG_ACTIVE_LOW=0 and 7'h7F when SEG_ACTIVE_LOW=1.

## Timing
- Reset state (async assert): shadow=0, div=0, idx=0, frame counter=0, phase=1 (visible), seg=off, dig_en=0, frame_tick=0.
- First edge after release: dig_en=0001 and seg=decode(shadow nibble 0)=3F.
- Output registers sample the current idx and shadow each cycle:
  - load at edge t changes seg at edge t+1;
  - an idx change at edge t is reflected in seg/dig_en at edge t+1.
- Digit dwell is exactly SCAN_DIV cycles per digit. SCAN_DIV=1 advances every cycle. A frame is N_DIGITS*SCAN_DIV cycles.
- frame_tick is registered and high for the one cycle after idx wraps to 0, i.e. aligned with dig_en returning to digit 0.
- Load coinciding with an idx advance: the newly selected digit shows the new value one edge later. There is no stale extra cycle beyond the defined latency.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). The scan restarts from digit 0.
- N_DIGITS=1: idx is constant, dig_en stays 1 after reset, and frame_tick pulses every SCAN_DIV cycles.

## Structure
- Package `hex_display_pkg`: the 16 segment pattern constants, SEG_OFF, and a function `hex_to_seg(nibble)`.
- Sub-module `hex_seg_encode`: combinational nibble -> 7-bit active-high segments, instanced once on the muxed nibble. Polarity inversion and blanking are applied in the top before the output register.

## Test plan
Unless stated, N_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset release, load value 16'h12AF -> dig_en cycles 0001,0010,0100,1000 with 4 cycles each; seg = 71,77,5B,06; frame_tick pulses on each return to 0001.
- Load 16'h0000 with lz_blank=1 -> digits 1..3 show 00, digit 0 shows 3F. Then load 16'h0300 -> digit 3 blank, digits 2,1,0 show 4F,3F,3F.
- blink_en=1 -> seg alternates between decoded and 00 every 2 frames (32 cycles). dig_en is unaffected.
- SEG_ACTIVE_LOW=1, value 16'h0008 -> digit 0 seg=00, blanked digits seg=7F.
- Assert resetn low mid-digit 2 -> seg=off and dig_en=0 immediately. After release, digit 0 is enabled on the first edge and shadow=0.
- Load asserted on the same edge idx advances, with SCAN_DIV=1 and N_DIGITS=1 -> new value appears exactly one edge later, and frame_tick is high every cycle.
